// File: rtl/tfhe_axil_cmd_master_if.sv
// Command/response port and AXI4-Lite master bus for the TFHE control-register initiator.
// The master modport is the initiator's view; the slave modport is the environment's view.
interface tfhe_axil_cmd_master_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [DATA_W-1:0]     cmd_wdata;
    logic [DATA_W/8-1:0]   cmd_wstrb;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic [1:0]            rsp_resp;
    logic                  rsp_timeout;
    logic                  busy;

    logic [ADDR_W-1:0]     M_AXI_AWADDR;
    logic [2:0]            M_AXI_AWPROT;
    logic                  M_AXI_AWVALID;
    logic                  M_AXI_AWREADY;
    logic [DATA_W-1:0]     M_AXI_WDATA;
    logic [DATA_W/8-1:0]   M_AXI_WSTRB;
    logic                  M_AXI_WVALID;
    logic                  M_AXI_WREADY;
    logic [1:0]            M_AXI_BRESP;
    logic                  M_AXI_BVALID;
    logic                  M_AXI_BREADY;
    logic [ADDR_W-1:0]     M_AXI_ARADDR;
    logic [2:0]            M_AXI_ARPROT;
    logic                  M_AXI_ARVALID;
    logic                  M_AXI_ARREADY;
    logic [DATA_W-1:0]     M_AXI_RDATA;
    logic [1:0]            M_AXI_RRESP;
    logic                  M_AXI_RVALID;
    logic                  M_AXI_RREADY;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, busy,
        output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, busy,
        input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );
endinterface

// File: rtl/tfhe_axil_cmd_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI transaction out, one response back,
// with a per-transaction timeout so a hung control slave cannot stall the sequencer.
module tfhe_axil_cmd_master #(
    parameter int          C_M_AXI_DATA_WIDTH = 32,
    parameter int          C_M_AXI_ADDR_WIDTH = 6,
    parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
    input  logic                   S_AXI_ACLK,
    input  logic                   S_AXI_ARESETN,
    tfhe_axil_cmd_master_if.master bus,
    output logic [2:0]             state_o
);
    localparam int          DW     = C_M_AXI_DATA_WIDTH;
    localparam int          AW     = C_M_AXI_ADDR_WIDTH;
    localparam bit          TMO_EN = (TIMEOUT_CYCLES != 0);
    localparam int unsigned CNT_W  = TMO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned LIM_I  = TMO_EN ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LIM = LIM_I[CNT_W-1:0];

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_AW_W = 3'd1,
        S_WR_B    = 3'd2,
        S_RD_AR   = 3'd3,
        S_RD_R    = 3'd4,
        S_RESP    = 3'd5
    } state_t;

    state_t              state_q;
    logic                cmd_ready_q;
    logic                rsp_valid_q;
    logic [DW-1:0]       rsp_rdata_q;
    logic [1:0]          rsp_resp_q;
    logic                rsp_timeout_q;
    logic [AW-1:0]       awaddr_q;
    logic                awvalid_q;
    logic [DW-1:0]       wdata_q;
    logic [DW/8-1:0]     wstrb_q;
    logic                wvalid_q;
    logic                bready_q;
    logic [AW-1:0]       araddr_q;
    logic                arvalid_q;
    logic                rready_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                tmo_hit;
    logic                aw_done;
    logic                w_done;
    logic [AW-1:0]       word_addr;

    // A channel transfers on the rising edge where its VALID and READY are both high; a VALID and its
    // payload never change while waiting for READY, and a handshake in the expiry cycle beats the timeout.
    assign tmo_hit   = TMO_EN && (cnt_q >= CNT_LIM);
    assign cnt_d     = (cnt_q >= CNT_LIM) ? cnt_q : cnt_q + 1'b1;
    assign aw_done   = !awvalid_q || bus.M_AXI_AWREADY;
    assign w_done    = !wvalid_q  || bus.M_AXI_WREADY;
    assign word_addr = {bus.cmd_addr[AW-1:2], 2'b00};

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q       <= S_IDLE;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= 2'b00;
            rsp_timeout_q <= 1'b0;
            awaddr_q      <= '0;
            awvalid_q     <= 1'b0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            araddr_q      <= '0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            cnt_q         <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (cmd_ready_q && bus.cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        if (bus.cmd_write) begin
                            awaddr_q  <= word_addr;
                            wdata_q   <= bus.cmd_wdata;
                            wstrb_q   <= bus.cmd_wstrb;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= S_WR_AW_W;
                        end else begin
                            araddr_q  <= word_addr;
                            arvalid_q <= 1'b1;
                            state_q   <= S_RD_AR;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                S_WR_AW_W: begin
                    if (aw_done && w_done) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b0;
                        bready_q  <= 1'b1;
                        cnt_q     <= cnt_d;
                        state_q   <= S_WR_B;
                    end else if (tmo_hit) begin
                        awvalid_q     <= 1'b0;
                        wvalid_q      <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_resp_q    <= 2'b10;
                        rsp_timeout_q <= 1'b1;
                        rsp_rdata_q   <= '0;
                        state_q       <= S_RESP;
                    end else begin
                        if (bus.M_AXI_AWREADY) awvalid_q <= 1'b0;
                        if (bus.M_AXI_WREADY)  wvalid_q  <= 1'b0;
                        cnt_q <= cnt_d;
                    end
                end
                S_WR_B: begin
                    if (bus.M_AXI_BVALID) begin
                        bready_q      <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_resp_q    <= bus.M_AXI_BRESP;
                        rsp_timeout_q <= 1'b0;
                        rsp_rdata_q   <= '0;
                        state_q       <= S_RESP;
                    end else if (tmo_hit) begin
                        bready_q      <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_resp_q    <= 2'b10;
                        rsp_timeout_q <= 1'b1;
                        rsp_rdata_q   <= '0;
                        state_q       <= S_RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_RD_AR: begin
                    if (bus.M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        cnt_q     <= cnt_d;
                        state_q   <= S_RD_R;
                    end else if (tmo_hit) begin
                        arvalid_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_resp_q    <= 2'b10;
                        rsp_timeout_q <= 1'b1;
                        rsp_rdata_q   <= '0;
                        state_q       <= S_RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_RD_R: begin
                    if (bus.M_AXI_RVALID) begin
                        rready_q      <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_resp_q    <= bus.M_AXI_RRESP;
                        rsp_timeout_q <= 1'b0;
                        rsp_rdata_q   <= bus.M_AXI_RDATA;
                        state_q       <= S_RESP;
                    end else if (tmo_hit) begin
                        rready_q      <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_resp_q    <= 2'b10;
                        rsp_timeout_q <= 1'b1;
                        rsp_rdata_q   <= '0;
                        state_q       <= S_RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_RESP: begin
                    // cmd_ready is re-raised by IDLE, so the next command lands one cycle after return.
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_rdata     = rsp_rdata_q;
    assign bus.rsp_resp      = rsp_resp_q;
    assign bus.rsp_timeout   = rsp_timeout_q;
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.M_AXI_AWADDR  = awaddr_q;
    assign bus.M_AXI_AWPROT  = 3'b000;
    assign bus.M_AXI_AWVALID = awvalid_q;
    assign bus.M_AXI_WDATA   = wdata_q;
    assign bus.M_AXI_WSTRB   = wstrb_q;
    assign bus.M_AXI_WVALID  = wvalid_q;
    assign bus.M_AXI_BREADY  = bready_q;
    assign bus.M_AXI_ARADDR  = araddr_q;
    assign bus.M_AXI_ARPROT  = 3'b000;
    assign bus.M_AXI_ARVALID = arvalid_q;
    assign bus.M_AXI_RREADY  = rready_q;
    assign state_o           = state_q;
endmodule

// File: doc/tfhe_axil_cmd_master.md
Name: tfhe_axil_cmd_master

Overview:
- AXI4-Lite initiator (master) that issues single-beat register writes and reads to the TFHE control slave: start_pbs/hbm_select word, host address/length registers, status.
- Accepts one command at a time on a valid/ready command port, runs the full AXI4-Lite transaction and returns the response on a valid/ready response port.
- Sits between the host-side sequencer (or a test/bring-up FSM) and the TFHE control register block.
- Includes a per-transaction timeout so a hung slave cannot lock up the sequencer.

Parameters:
- C_M_AXI_DATA_WIDTH, 32: AXI data width; only 32 is supported.
- C_M_AXI_ADDR_WIDTH, 6: AXI address width; matches the 6-register control map at 0x00–0x14.
- TIMEOUT_CYCLES, 1024: cycles allowed per transaction, measured from command acceptance; 0 disables the timeout.

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESETN  in  1  reset: asynchronous, active-low; clock S_AXI_ACLK.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write byte strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout.
- rsp_timeout  out  1  response was generated by timeout.
- busy  out  1  state != IDLE.
- M_AXI_AWADDR out ADDR_W; M_AXI_AWPROT out 3; M_AXI_AWVALID out 1; M_AXI_AWREADY in 1.
- M_AXI_WDATA out 32; M_AXI_WSTRB out 4; M_AXI_WVALID out 1; M_AXI_WREADY in 1.
- M_AXI_BRESP in 2; M_AXI_BVALID in 1; M_AXI_BREADY out 1.
- M_AXI_ARADDR out ADDR_W; M_AXI_ARPROT out 3; M_AXI_ARVALID out 1; M_AXI_ARREADY in 1.
- M_AXI_RDATA in 32; M_AXI_RRESP in 2; M_AXI_RVALID in 1; M_AXI_RREADY out 1.

Behaviour:

Reset:
- All outputs 0: cmd_ready, rsp_*, busy, all *VALID, BREADY, RREADY, addresses, data, strobes.
- State IDLE; timeout counter cleared.
- Assertion mid-transaction aborts immediately, with no response.
- cmd_ready rises on the first clock after deassertion.

Address and protection:
- AWADDR/ARADDR = cmd_addr with bits [1:0] forced to 0.
- AWPROT/ARPROT = 3'b000.

States:
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, latch cmd_* and go to WR_AW_W (write) or RD_AR (read).
  - cmd_ready drops the cycle after acceptance.
- WR_AW_W:
  - AWVALID and WVALID both assert the cycle after acceptance.
  - Each channel deasserts independently on its own handshake; either order, or the same cycle, is legal.
  - When both have completed, go to WR_B.
- WR_B:
  - BREADY = 1.
  - On BVALID, capture BRESP, set rsp_rdata = 0, go to RESP.
- RD_AR:
  - ARVALID = 1 until ARREADY, then go to RD_R.
- RD_R:
  - RREADY = 1.
  - On RVALID, capture RDATA/RRESP and go to RESP.
- RESP:
  - rsp_valid = 1, held stable until rsp_ready.
  - On rsp_ready, go to IDLE; next command can be accepted one cycle later.

Timing and AXI rules:
- Minimum write with an always-ready slave: accept at T, AW/W handshake at T+1, B at T+2, rsp_valid at T+3.
- Minimum read: AR handshake at T+1, R at T+2, rsp_valid at T+3.
- Once asserted, a VALID and its payload hold stable until handshake.
- At most one outstanding transaction.

Timeout:
- The counter runs in WR_AW_W, WR_B, RD_AR and RD_R.
- When it reaches TIMEOUT_CYCLES:
  - Force all *VALID/READY low.
  - Set rsp_resp = 2'b10, rsp_timeout = 1, rsp_rdata = 0.
  - Go to RESP.
- A handshake completing in the expiry cycle takes priority over the timeout.
- The counter clears on entry to IDLE.
- TIMEOUT_CYCLES = 0 means no timeout.

Back-pressure:
- rsp_ready held low keeps the block in RESP; cmd_ready stays 0.
- SLVERR/DECERR from the slave is passed through with rsp_timeout = 0.

Test Plan:
1. Write 0x00 data 0x00000001 strobe 0xF, slave always ready -> AW/W at T+1, BREADY handshake, rsp_valid at T+3, rsp_resp = 0, rsp_rdata = 0; slave start_pbs = 1.
2. Write 0x04 data 0xDEADBEEF, then read 0x04 -> rsp_rdata = 0xDEADBEEF, rsp_resp = 0.
3. Slave delays WREADY 5 cycles after AWREADY -> AWVALID drops after its handshake; WVALID and WDATA stay stable 5 cycles; exactly one write reaches the slave.
4. TIMEOUT_CYCLES = 16, slave never asserts ARREADY -> ARVALID drops at cycle 16; rsp_resp = 2'b10, rsp_timeout = 1; next command is accepted.
5. rsp_ready held low 10 cycles with cmd_valid high -> rsp_valid and rsp_rdata stable, cmd_ready = 0 throughout; second command accepted the cycle after rsp handshake + 1.
6. Assert S_AXI_ARESETN low during WR_B -> all outputs 0 asynchronously; after release, cmd_ready = 1 and no stale rsp_valid.
